// File: rtl/mem_boot_loader.sv
// Boot loader: turns a header-framed valid/ready word stream into registered
// write pulses for the instruction and data BRAMs, then releases the core.
module mem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  init_done,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic                  boot_q, boot_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  ie_q, ie_d;
  logic                  de_q, de_d;
  logic                  hs;
  logic                  unused_hdr_bits;

  // Valid/ready: a word transfers on a rising clk edge where s_valid and
  // s_ready are both high; s_ready depends only on state (and rst), never on s_valid.
  assign s_ready         = !rst && (state_q != ST_DONE);
  assign hs              = s_valid && s_ready;
  assign unused_hdr_bits = ^s_data;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    boot_d  = boot_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    ie_d    = 1'b0;
    de_d    = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (hs) begin
          tgt_d  = s_data[31];
          boot_d = s_data[30];
          cnt_d  = s_data[16 +: CNT_WIDTH];
          addr_d = {s_data[ADDR_WIDTH-1:2], 2'b00};
          if (s_data[1:0] != 2'b00) err_d = 1'b1;
          if (s_data[16 +: CNT_WIDTH] != '0) state_d = ST_PAYLOAD;
          else if (s_data[30])               state_d = ST_DONE;
        end
      end
      ST_PAYLOAD: begin
        if (hs) begin
          wa_d   = addr_q;
          wd_d   = s_data;
          ie_d   = !tgt_q;
          de_d   = tgt_q;
          addr_d = addr_q + ADDR_STEP;
          // Stepping off the top of the BRAM wraps to 0 and is flagged.
          if (addr_q == ADDR_LAST) err_d = 1'b1;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = boot_q ? ST_DONE : ST_HDR;
        end
      end
      ST_DONE: begin
        if (reload) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HDR;
      tgt_q   <= 1'b0;
      boot_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      ie_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      boot_q  <= boot_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      ie_q    <= ie_d;
      de_q    <= de_d;
    end
  end

  // Both BRAM ports share one address/data register; only the enables differ.
  assign i_w_addr  = wa_q;
  assign i_w_dat   = wd_q;
  assign i_w_enb   = ie_q;
  assign d_w_addr  = wa_q;
  assign d_w_dat   = wd_q;
  assign d_w_enb   = de_q;
  assign pc_stall  = (state_q != ST_DONE);
  assign init_done = (state_q == ST_DONE);
  assign busy      = (state_q == ST_PAYLOAD);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed + randomized bench for mem_boot_loader with a word-level
// reference model and a scoreboard of expected BRAM writes.
module tb_mem_boot_loader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 10;
  localparam int EW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          reload = 1'b0;
  logic [AW-1:0] i_w_addr, d_w_addr;
  logic [DW-1:0] i_w_dat, d_w_dat;
  logic          i_w_enb, d_w_enb;
  logic          pc_stall, init_done, busy, err;
  logic [1:0]    dbg_state;

  mem_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .reload(reload), .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .pc_stall(pc_stall),
    .init_done(init_done), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard + reference model state
  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic          m_tgt, m_boot, m_err, m_done;
  int            m_addr, m_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_tgt = 0; m_boot = 0; m_err = 0; m_done = 0; m_addr = 0; m_left = 0;
  endtask

  task automatic model_hdr(input logic [DW-1:0] h);
    m_tgt  = h[31];
    m_boot = h[30];
    m_left = int'(h[16 +: CW]);
    m_addr = (int'(h[AW-1:0]) / 4) * 4;
    if (h[1:0] != 2'b00) m_err = 1;
    m_done = (m_left == 0) && m_boot;
  endtask

  task automatic model_pay(input logic [DW-1:0] w);
    logic [AW-1:0] a;
    a = AW'(m_addr);
    exp_q.push_back({m_tgt, a, w});
    m_addr = m_addr + 4;
    if (m_addr >= (1 << AW)) begin
      m_addr = m_addr - (1 << AW);
      m_err  = 1;
    end
    m_left = m_left - 1;
    if (m_left == 0) m_done = m_boot;
  endtask

  // write monitor: every enable pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && (i_w_enb || d_w_enb)) begin
      chk("dual_enb", 64'(i_w_enb && d_w_enb), 64'd0);
      chk("wr_latency", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0)
        chk("wr", 64'({d_w_enb, d_w_enb ? d_w_addr : i_w_addr, d_w_enb ? d_w_dat : i_w_dat}),
            64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic send_word(input logic [DW-1:0] w, output bit ok);
    int n;
    ok = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 s_valid = 1'b0;
      ok = 1;
    end
  endtask

  task automatic send_hdr(input logic [DW-1:0] h);
    bit ok;
    send_word(h, ok);
    if (ok) model_hdr(h);
  endtask

  task automatic send_pay(input logic [DW-1:0] w, input int gap);
    bit ok;
    repeat (gap) @(negedge clk);
    send_word(w, ok);
    if (ok) model_pay(w);
  endtask

  task automatic burst(input logic [DW-1:0] h, input int gap_lo, input int gap_hi);
    int n;
    n = int'(h[16 +: CW]);
    send_hdr(h);
    for (int i = 0; i < n; i++) send_pay($urandom, int'($urandom_range(gap_hi, gap_lo)));
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, ".pc_stall"},  64'(pc_stall),  64'(!m_done));
    chk({tag, ".init_done"}, 64'(init_done), 64'(m_done));
    chk({tag, ".busy"},      64'(busy),      64'(!m_done && m_left > 0));
    chk({tag, ".s_ready"},   64'(s_ready),   64'(!m_done));
    chk({tag, ".err"},       64'(err),       64'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst.pc_stall",  64'(pc_stall),  64'd1);
    chk("rst.init_done", 64'(init_done), 64'd0);
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.err",       64'(err),       64'd0);
    chk("rst.enb",       64'({i_w_enb, d_w_enb}), 64'd0);
    chk("rst.addr",      64'({i_w_addr, d_w_addr}), 64'd0);
    chk("rst.dat",       64'({i_w_dat, d_w_dat}), 64'd0);
    chk("rst.s_ready",   64'(s_ready),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rel.s_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    if (m_done) m_done = 0;
  endtask

  // stimulus
  initial begin
    logic [DW-1:0] h;
    model_reset();
    do_reset();
    check_status("idle");
    do_reload();
    check_status("reload_ignored");

    send_hdr(32'h8002_0000);
    check_status("dmem_hdr");
    send_pay(32'h0000_0003, 0);
    send_pay(32'h0000_0002, 0);
    check_status("dmem_end");

    burst(32'hC005_0000, 0, 0);
    check_status("imem_boot");
    do_reload();
    check_status("reload");

    burst(32'h8004_0040, 1, 1);
    check_status("toggle_valid");

    for (int k = 0; k < 6; k++) begin
      h = '0;
      h[31] = 1'($urandom_range(1, 0));
      h[16 +: CW] = CW'($urandom_range(6, 1));
      h[AW-1:0] = AW'($urandom_range((1 << AW) - 1, 0) & ~3);
      burst(h, 0, 2);
      check_status("rand_burst");
    end

    do_reset();
    burst(32'h0002_03FC, 0, 0);
    check_status("wrap");
    burst(32'h8001_0100, 0, 1);
    check_status("wrap_sticky");

    do_reset();
    burst(32'h0001_0002, 0, 0);
    check_status("misaligned");

    do_reset();
    send_hdr(32'h0003_0000);
    send_pay($urandom, 0);
    do_reset();
    send_hdr(32'h4000_0000);
    check_status("boot_n0");
    do_reload();
    check_status("boot_n0_reload");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
